// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the UART TX FIFO write port between NREQ requesters.
// Optional idle-stall grant revocation is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int DBIT   = 8,
  parameter int PTR_W  = 2,
  parameter int TO_CYC = 1023,
  parameter int TO_W   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 timeout_flag
);

  if ((1 << PTR_W) < NREQ || TO_CYC >= (1 << TO_W)) begin : g_param_check
    $error("uart_tx_arbiter: PTR_W or TO_W too narrow");
  end

  typedef enum logic {IDLE, XFER} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] win;
  logic             found;
  logic             owner_valid;
  logic             owner_last;
  logic [DBIT-1:0]  owner_data;
  logic             to_hit;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_W-1:0]  stall_q, stall_d;
  assign to_hit = (state_q == XFER) && (stall_q == TO_W'(TO_CYC));
`else
  assign to_hit = 1'b0;
`endif

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_data  = req_data[owner_q*DBIT +: DBIT];
  assign next_ptr    = (owner_q == PTR_W'(NREQ-1)) ? '0 : owner_q + 1'b1;

  // Rotating scan from rr_q; wrap is explicit so indices >= NREQ are never visited.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_p;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_p = PTR_W'(idx);
      if (!found && req_valid[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    req_ready    = '0;
    wr_uart      = 1'b0;
    w_data       = '0;
    grant        = '0;
    busy         = 1'b0;
    timeout_flag = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    stall_d      = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          owner_d = win;
`ifdef UART_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      XFER: begin
        busy           = 1'b1;
        grant[owner_q] = 1'b1;
        if (!to_hit) begin
          req_ready[owner_q] = ~tx_full;
          wr_uart            = owner_valid & ~tx_full;
        end
        if (wr_uart) begin
          w_data = owner_data;
`ifdef UART_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (owner_last) begin
            state_d = IDLE;
            rr_d    = next_ptr;
          end
        end else if (to_hit) begin
          state_d      = IDLE;
          rr_d         = next_ptr;
          timeout_flag = 1'b1;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!owner_valid && !tx_full) begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed literal checks, then random traffic vs a packet-level model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DBIT = 8;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_CYC_TB = 8;
`else
  localparam int TO_CYC_TB = 1023;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        tx_full, wr_uart, busy, timeout_flag;
  logic [7:0]  w_data;

  int total = 0;
  int pass  = 0;

  int         m_owner, m_rr, m_stall;
  int         plen[NREQ];
  int         ppos[NREQ];
  int         gap[NREQ];
  logic [7:0] pbytes[NREQ][8];

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .PTR_W(2), .TO_CYC(TO_CYC_TB), .TO_W(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .grant(grant), .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic wr, input logic [7:0] d,
                         input logic [3:0] rdy, input logic b);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".wr_uart"}, 32'(wr_uart), 32'(wr));
    chk({tag, ".w_data"}, 32'(w_data), 32'(d));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic new_pkt(input int i);
    plen[i] = $urandom_range(1, 5);
    ppos[i] = 0;
    for (int j = 0; j < 8; j++) pbytes[i][j] = 8'($urandom);
    gap[i] = $urandom_range(0, 6);
  endtask

  task automatic setreq(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
    #12;
    chk_all("rst", 4'b0, 1'b0, 8'h0, 4'b0, 1'b0);
    chk("rst.timeout_flag", 32'(timeout_flag), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Packet E5,95,CC from requester 0
    @(negedge clk); setreq(0, 1'b1, 8'hE5, 1'b0); #1;
    chk_all("arb0", 4'b0, 1'b0, 8'h0, 4'b0, 1'b0);
    @(negedge clk); #1;
    chk_all("b0", 4'b0001, 1'b1, 8'hE5, 4'b0001, 1'b1);
    @(negedge clk); setreq(0, 1'b1, 8'h95, 1'b0); #1;
    chk_all("b1", 4'b0001, 1'b1, 8'h95, 4'b0001, 1'b1);
    @(negedge clk); setreq(0, 1'b1, 8'hCC, 1'b1); #1;
    chk_all("b2", 4'b0001, 1'b1, 8'hCC, 4'b0001, 1'b1);
    @(negedge clk); setreq(0, 1'b0, 8'h00, 1'b0); #1;
    chk_all("idle0", 4'b0, 1'b0, 8'h0, 4'b0, 1'b0);

    // rr pointer now 1: requesters 0 and 2 pending -> 2 first, then wrap to 0
    @(negedge clk); setreq(0, 1'b1, 8'h11, 1'b1); setreq(2, 1'b1, 8'h22, 1'b1); #1;
    chk("arb02.grant", 32'(grant), 32'd0);
    @(negedge clk); #1;
    chk_all("r2", 4'b0100, 1'b1, 8'h22, 4'b0100, 1'b1);
    @(negedge clk); setreq(2, 1'b0, 8'h00, 1'b0); #1;
    chk_all("gap", 4'b0, 1'b0, 8'h0, 4'b0, 1'b0);
    @(negedge clk); #1;
    chk_all("r0wrap", 4'b0001, 1'b1, 8'h11, 4'b0001, 1'b1);
    @(negedge clk); setreq(0, 1'b0, 8'h00, 1'b0);

    // Requester 1 with tx_full back-pressure, then owner stall
    setreq(1, 1'b1, 8'h77, 1'b0); tx_full = 1'b1; #1;
    chk("arb1.grant", 32'(grant), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk_all("full", 4'b0010, 1'b0, 8'h0, 4'b0, 1'b1);
    end
    @(negedge clk); tx_full = 1'b0; #1;
    chk_all("unfull", 4'b0010, 1'b1, 8'h77, 4'b0010, 1'b1);
    @(negedge clk); setreq(1, 1'b0, 8'h00, 1'b0);
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      #1; chk("stall.grant", 32'(grant), 32'b0010); chk("stall.to", 32'(timeout_flag), 32'd0);
      @(negedge clk);
    end
    #1; chk("revoke.to", 32'(timeout_flag), 32'd1); chk("revoke.wr", 32'(wr_uart), 32'd0);
    @(negedge clk); #1;
    chk("after.to", 32'(timeout_flag), 32'd0); chk("after.grant", 32'(grant), 32'd0);
`else
    for (int k = 0; k < 120; k++) begin
      #1; chk("hold.grant", 32'(grant), 32'b0010); chk("hold.to", 32'(timeout_flag), 32'd0);
      @(negedge clk);
    end
    setreq(1, 1'b1, 8'h88, 1'b1); #1;
    chk_all("hold.last", 4'b0010, 1'b1, 8'h88, 4'b0010, 1'b1);
    @(negedge clk); setreq(1, 1'b0, 8'h00, 1'b0); #1;
    chk("hold.idle", 32'(busy), 32'd0);
`endif

    // Asynchronous reset mid-packet; arbitration restarts from requester 0
    @(negedge clk); setreq(2, 1'b1, 8'hAB, 1'b0); #1;
    @(negedge clk); #1;
    chk_all("pre_rst", 4'b0100, 1'b1, 8'hAB, 4'b0100, 1'b1);
    #2 reset = 1'b0; #1;
    chk_all("async_rst", 4'b0, 1'b0, 8'h0, 4'b0, 1'b0);
    @(negedge clk); reset = 1'b1; setreq(2, 1'b0, 8'h00, 1'b0);
    setreq(1, 1'b1, 8'h5A, 1'b1); setreq(3, 1'b1, 8'hA5, 1'b1); #1;
    chk("rearb.grant", 32'(grant), 32'd0);
    @(negedge clk); #1;
    chk_all("restart", 4'b0010, 1'b1, 8'h5A, 4'b0010, 1'b1);

    // Random traffic against the packet-level model
    @(negedge clk); reset = 1'b0; req_valid = '0; req_last = '0; tx_full = 1'b0;
    m_owner = -1; m_rr = 0; m_stall = 0;
    for (int i = 0; i < NREQ; i++) new_pkt(i);
    @(negedge clk); reset = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       exp_to, exp_wr;
      logic [3:0] exp_g, exp_rdy;
      logic [7:0] exp_d;
      int         o;
      @(negedge clk);
      tx_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (gap[i] == 0 && $urandom_range(0, 49) == 0) gap[i] = $urandom_range(5, 15);
        if (gap[i] > 0) begin
          gap[i]--;
          setreq(i, 1'b0, 8'($urandom), 1'($urandom));
        end else if ($urandom_range(0, 3) != 0) begin
          setreq(i, 1'b1, pbytes[i][ppos[i]], ppos[i] == plen[i] - 1);
        end else begin
          setreq(i, 1'b0, 8'($urandom), 1'($urandom));
        end
      end
      #1;
      o       = m_owner;
      exp_to  = (o >= 0) && (m_stall == TO_CYC_TB);
      exp_wr  = (o >= 0) && !exp_to && req_valid[o] && !tx_full;
      exp_g   = (o >= 0) ? 4'(1 << o) : 4'b0;
      exp_rdy = (o >= 0 && !exp_to && !tx_full) ? 4'(1 << o) : 4'b0;
      exp_d   = exp_wr ? req_data[o*8 +: 8] : 8'h00;
      chk_all("rnd", exp_g, exp_wr, exp_d, exp_rdy, o >= 0);
      chk("rnd.timeout_flag", 32'(timeout_flag), 32'(exp_to));
      if (o < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req_valid[(m_rr + k) % NREQ]) begin
            m_owner = (m_rr + k) % NREQ;
            m_stall = 0;
            break;
          end
        end
      end else if (exp_wr) begin
        m_stall = 0;
        if (req_last[o]) begin
          m_owner = -1;
          m_rr    = (o + 1) % NREQ;
          new_pkt(o);
        end else begin
          ppos[o]++;
        end
      end else if (exp_to) begin
        m_owner = -1;
        m_rr    = (o + 1) % NREQ;
      end else if (!req_valid[o] && !tx_full) begin
        m_stall++;
      end
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
